// File: rtl/wt_cache_pkg.sv
// Shared types and defaults for the write-through word cache.
// Holds the state encodings of the upstream and write-buffer FSMs.
package wt_cache_pkg;

    localparam int unsigned DefAddrWidth = 64;
    localparam int unsigned DefDataWidth = 64;
    localparam int unsigned DefLineCount = 64;

    typedef enum logic [1:0] {StIdle, StHold, StFillReq, StFillWait} up_state_e;
    typedef enum logic [1:0] {WbEmpty, WbIssue, WbBusy} wb_state_e;

    function automatic int unsigned idx_width(input int unsigned lines);
        return $clog2(lines);
    endfunction

endpackage

// File: rtl/wt_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational read port,
// one write port, valid bits cleared by reset.
module wt_cache_array
    import wt_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned LINE_COUNT = DefLineCount,
    localparam int unsigned IdxW = idx_width(LINE_COUNT),
    localparam int unsigned TagW = ADDR_WIDTH - IdxW
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [IdxW-1:0]       rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TagW-1:0]       rd_tag_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_en_i,
    input  logic [IdxW-1:0]       wr_idx_i,
    input  logic [TagW-1:0]       wr_tag_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);

    logic [LINE_COUNT-1:0] valid_q;
    logic [TagW-1:0]       tag_q  [LINE_COUNT];
    logic [DATA_WIDTH-1:0] data_q [LINE_COUNT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are qualified by the valid bit.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/wt_cache.sv
// Direct-mapped, write-through, write-allocate word cache with a one-entry posted
// write buffer; the registered mem_addr/mem_din outputs double as the buffer contents.
module wt_cache
    import wt_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned LINE_COUNT = DefLineCount
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    input  logic                  re_i,
    input  logic                  we_i,
    output logic                  ready_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_din_o,
    input  logic [DATA_WIDTH-1:0] mem_dout_i,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    input  logic                  mem_ready_i
);

    localparam int unsigned IdxW = idx_width(LINE_COUNT);
    localparam int unsigned TagW = ADDR_WIDTH - IdxW;

    up_state_e             state_q, state_d;
    wb_state_e             wb_state_q, wb_state_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  mem_re_q, mem_re_d;
    logic                  mem_we_q, mem_we_d;
    logic                  req_we_q, req_we_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_data_q, req_data_d;

    logic                  rd_valid;
    logic [TagW-1:0]       rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  line_we;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [DATA_WIDTH-1:0] line_data;

    logic                  accept, acc_write, acc_read, hit;
    logic                  wb_free, wb_clear, wb_load;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;

    wt_cache_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .LINE_COUNT(LINE_COUNT)
    ) u_array (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rd_idx_i  (addr_i[IdxW-1:0]),
        .rd_valid_o(rd_valid),
        .rd_tag_o  (rd_tag),
        .rd_data_o (rd_data),
        .wr_en_i   (line_we),
        .wr_idx_i  (line_addr[IdxW-1:0]),
        .wr_tag_i  (line_addr[ADDR_WIDTH-1:IdxW]),
        .wr_data_i (line_data)
    );

    assign accept    = ready_q & (re_i | we_i);
    assign acc_write = accept & we_i;
    assign acc_read  = accept & ~we_i;
    assign hit       = rd_valid && (rd_tag == addr_i[ADDR_WIDTH-1:IdxW]);
    assign wb_free   = (wb_state_q == WbEmpty);
    // Buffer is usable on this edge: already empty, or its write completes now.
    assign wb_clear  = wb_free || ((wb_state_q == WbBusy) && mem_ready_i);

    always_comb begin
        state_d    = state_q;
        wb_state_d = wb_state_q;
        ready_d    = ready_q;
        dout_d     = dout_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_re_d   = 1'b0;
        mem_we_d   = 1'b0;
        req_we_d   = req_we_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        wb_load    = 1'b0;
        load_addr  = addr_i;
        load_data  = din_i;
        line_we    = 1'b0;
        line_addr  = addr_i;
        line_data  = din_i;

        unique case (state_q)
            StIdle: begin
                if (acc_write) begin
                    line_we = 1'b1;
                    if (wb_free) begin
                        wb_load = 1'b1;
                    end else begin
                        state_d = StHold;
                        ready_d = 1'b0;
                    end
                end else if (acc_read && hit) begin
                    dout_d = rd_data;
                end else if (acc_read && wb_free) begin
                    state_d    = StFillReq;
                    ready_d    = 1'b0;
                    mem_re_d   = 1'b1;
                    mem_addr_d = addr_i;
                end else if (acc_read) begin
                    state_d = StHold;
                    ready_d = 1'b0;
                end
                if (accept) begin
                    req_we_d   = we_i;
                    req_addr_d = addr_i;
                    req_data_d = din_i;
                end
            end
            StHold: begin
                if (wb_clear && req_we_q) begin
                    wb_load   = 1'b1;
                    load_addr = req_addr_q;
                    load_data = req_data_q;
                    state_d   = StIdle;
                    ready_d   = 1'b1;
                end else if (wb_clear) begin
                    state_d    = StFillReq;
                    mem_re_d   = 1'b1;
                    mem_addr_d = req_addr_q;
                end
            end
            StFillReq: begin
                state_d = StFillWait;
            end
            StFillWait: begin
                if (mem_ready_i) begin
                    line_we   = 1'b1;
                    line_addr = req_addr_q;
                    line_data = mem_dout_i;
                    dout_d    = mem_dout_i;
                    ready_d   = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        unique case (wb_state_q)
            WbEmpty: if (wb_load) wb_state_d = WbIssue;
            WbIssue: wb_state_d = WbBusy;
            WbBusy:  if (mem_ready_i) wb_state_d = wb_load ? WbIssue : WbEmpty;
            default: wb_state_d = WbEmpty;
        endcase

        if (wb_load) begin
            mem_we_d   = 1'b1;
            mem_addr_d = load_addr;
            mem_din_d  = load_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            wb_state_q <= WbEmpty;
            ready_q    <= 1'b1;
            dout_q     <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            req_we_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wb_state_q <= wb_state_d;
            ready_q    <= ready_d;
            dout_q     <= dout_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            req_we_q   <= req_we_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
        end
    end

    assign dout_o     = dout_q;
    assign ready_o    = ready_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_din_o  = mem_din_q;
    assign mem_re_o   = mem_re_q;
    assign mem_we_o   = mem_we_q;

endmodule

// File: tb/tb_wt_cache.sv
// Directed bench for wt_cache: upstream request driver plus a 100-cycle-latency RAM model.
module tb_wt_cache;

    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 64;
    localparam int unsigned LC  = 64;
    localparam int unsigned Lat = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          re;
    logic          we;
    logic          ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          mem_re;
    logic          mem_we;
    logic          mem_ready;

    int n_cmp = 0;
    int n_bad = 0;
    int re_cnt = 0;
    int we_cnt = 0;

    always #5 clk = ~clk;

    wt_cache #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LINE_COUNT(LC)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .addr_i     (addr),
        .din_i      (din),
        .dout_o     (dout),
        .re_i       (re),
        .we_i       (we),
        .ready_o    (ready),
        .mem_addr_o (mem_addr),
        .mem_din_o  (mem_din),
        .mem_dout_i (mem_dout),
        .mem_re_o   (mem_re),
        .mem_we_o   (mem_we),
        .mem_ready_i(mem_ready)
    );

    // RAM model: unwritten words read as addr * 0x11.
    logic [DW-1:0] ram_mem [1024];
    logic [1023:0] ram_wr = '0;
    logic          ram_busy;
    int            ram_cnt;
    logic [9:0]    ram_rd_addr;

    function automatic logic [DW-1:0] ram_peek(input logic [9:0] a);
        return ram_wr[a] ? ram_mem[a] : DW'(a) * 64'h11;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ready   <= 1'b1;
            ram_busy    <= 1'b0;
            ram_cnt     <= 0;
            ram_rd_addr <= '0;
            mem_dout    <= '0;
        end else if (!ram_busy) begin
            if (mem_re || mem_we) begin
                ram_busy    <= 1'b1;
                mem_ready   <= 1'b0;
                ram_cnt     <= Lat - 1;
                ram_rd_addr <= mem_addr[9:0];
            end
        end else if (ram_cnt == 0) begin
            ram_busy  <= 1'b0;
            mem_ready <= 1'b1;
            mem_dout  <= ram_peek(ram_rd_addr);
        end else begin
            ram_cnt <= ram_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && !ram_busy && mem_we) begin
            ram_mem[mem_addr[9:0]] <= mem_din;
            ram_wr[mem_addr[9:0]]  <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mem_re) re_cnt <= re_cnt + 1;
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    // Present one request for exactly one edge; returns at the following negedge.
    task automatic issue(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        re   = r;
        we   = w;
        addr = a;
        din  = d;
        @(negedge clk);
        re = 1'b0;
        we = 1'b0;
    endtask

    task automatic wait_ready(input int limit, output int cycles);
        cycles = 0;
        while (ready !== 1'b1 && cycles < limit) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", ready); end
        n_cmp++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
            n_bad++; $display("FAIL reset_mem_req got re=%0b we=%0b want 0/0", mem_re, mem_we);
        end
        n_cmp++; if (dout !== '0 || mem_addr !== '0 || mem_din !== '0) begin
            n_bad++; $display("FAIL reset_regs got dout=%h ma=%h md=%h want 0", dout, mem_addr, mem_din);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready got %0b want 1", ready); end
    endtask

    task automatic test_miss_hit;
        int cyc;
        int re0;
        re0 = re_cnt;
        issue(1'b1, 1'b0, 64'd5, '0);
        wait_ready(400, cyc);
        n_cmp++; if (cyc != 102) begin n_bad++; $display("FAIL miss_stall got %0d want 102", cyc); end
        n_cmp++; if (dout !== 64'h55) begin n_bad++; $display("FAIL miss_data got %h want 55", dout); end
        n_cmp++; if (re_cnt - re0 != 1) begin n_bad++; $display("FAIL miss_mem_re got %0d want 1", re_cnt - re0); end
        re0 = re_cnt;
        issue(1'b1, 1'b0, 64'd5, '0);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL hit_ready got %0b want 1", ready); end
        n_cmp++; if (dout !== 64'h55) begin n_bad++; $display("FAIL hit_data got %h want 55", dout); end
        @(negedge clk);
        n_cmp++; if (re_cnt != re0) begin n_bad++; $display("FAIL hit_no_mem_re got %0d want 0", re_cnt - re0); end
    endtask

    task automatic test_posted_write;
        int we0;
        we0 = we_cnt;
        issue(1'b0, 1'b1, 64'd1, 64'h0123456789abcdef);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL pw_ready got %0b want 1", ready); end
        issue(1'b1, 1'b0, 64'd1, '0);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL raw_ready got %0b want 1", ready); end
        n_cmp++; if (dout !== 64'h0123456789abcdef) begin
            n_bad++; $display("FAIL raw_data got %h want 0123456789abcdef", dout);
        end
        repeat (110) @(negedge clk);
        n_cmp++; if (we_cnt - we0 != 1) begin n_bad++; $display("FAIL pw_mem_we got %0d want 1", we_cnt - we0); end
        n_cmp++; if (ram_peek(10'd1) !== 64'h0123456789abcdef) begin
            n_bad++; $display("FAIL pw_ram got %h want 0123456789abcdef", ram_peek(10'd1));
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int we0;
        we0 = we_cnt;
        issue(1'b0, 1'b1, 64'd2, 64'hAAAA_0000_0000_0002);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_first_ready got %0b want 1", ready); end
        issue(1'b0, 1'b1, 64'd3, 64'hBBBB_0000_0000_0003);
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold got %0b want 0", ready); end
        wait_ready(400, cyc);
        n_cmp++; if (cyc != 101) begin n_bad++; $display("FAIL b2b_stall got %0d want 101", cyc); end
        repeat (110) @(negedge clk);
        n_cmp++; if (we_cnt - we0 != 2) begin n_bad++; $display("FAIL b2b_mem_we got %0d want 2", we_cnt - we0); end
        n_cmp++; if (ram_peek(10'd2) !== 64'hAAAA_0000_0000_0002) begin
            n_bad++; $display("FAIL b2b_ram2 got %h want aaaa000000000002", ram_peek(10'd2));
        end
        n_cmp++; if (ram_peek(10'd3) !== 64'hBBBB_0000_0000_0003) begin
            n_bad++; $display("FAIL b2b_ram3 got %h want bbbb000000000003", ram_peek(10'd3));
        end
    endtask

    task automatic test_conflict;
        int cyc;
        int re0;
        re0 = re_cnt;
        issue(1'b0, 1'b1, 64'd64, 64'h77);
        issue(1'b1, 1'b0, 64'd0, '0);
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL cf_hold got %0b want 0", ready); end
        wait_ready(600, cyc);
        n_cmp++; if (cyc != 203) begin n_bad++; $display("FAIL cf_stall got %0d want 203", cyc); end
        n_cmp++; if (dout !== 64'h0) begin n_bad++; $display("FAIL cf_data0 got %h want 0", dout); end
        issue(1'b1, 1'b0, 64'd64, '0);
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL cf_evict_miss got %0b want 0", ready); end
        wait_ready(400, cyc);
        n_cmp++; if (cyc != 102) begin n_bad++; $display("FAIL cf_refill_stall got %0d want 102", cyc); end
        n_cmp++; if (dout !== 64'h77) begin n_bad++; $display("FAIL cf_data64 got %h want 77", dout); end
        n_cmp++; if (re_cnt - re0 != 2) begin n_bad++; $display("FAIL cf_mem_re got %0d want 2", re_cnt - re0); end
    endtask

    task automatic test_reset_mid_fill;
        int cyc;
        issue(1'b1, 1'b0, 64'd7, '0);
        repeat (10) @(negedge clk);
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rmf_busy got %0b want 0", ready); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rmf_ready got %0b want 1", ready); end
        n_cmp++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
            n_bad++; $display("FAIL rmf_mem_req got re=%0b we=%0b want 0/0", mem_re, mem_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b1, 1'b0, 64'd5, '0);
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rmf_invalidated got %0b want 0", ready); end
        wait_ready(400, cyc);
        n_cmp++; if (cyc != 102) begin n_bad++; $display("FAIL rmf_stall got %0d want 102", cyc); end
        n_cmp++; if (dout !== 64'h55) begin n_bad++; $display("FAIL rmf_data got %h want 55", dout); end
    endtask

    initial begin
        re    = 1'b0;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_miss_hit();
        test_posted_write();
        test_back_to_back();
        test_conflict();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
